ghost_move_ctrl: RTL and testbench
==================================

GHOST_MOVE_CTRL -- requirements
Module: ghost_move_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 22: maze width in tiles, which is also the map row width in bits.
REQ-002 SHALL have parameter ROWS, default 32: maze height in tiles.
REQ-003 SHALL have parameters START_X/START_Y, default 10/14: reset tile.
REQ-004 SHALL have parameters SCAT_X/SCAT_Y, default 21/0: scatter-mode target tile.
REQ-005 SHALL have parameter WRAP, default 1: horizontal tunnel wrap enable.
REQ-006 SHALL derive XW=$clog2(COLS) and YW=$clog2(ROWS).
REQ-007 SHALL have clk, input, 1: single clock; all logic is on the rising edge.
REQ-008 SHALL have reset, input, 1: synchronous, active-high.
REQ-009 SHALL have step_req, input, 1: request one tile move.
REQ-010 SHALL have mode, input, 2: 0 CHASE, 1 SCATTER, 2 FRIGHTENED, 3 FROZEN.
REQ-011 SHALL have target_x/target_y, input, XW/YW: chase target tile.
REQ-012 SHALL have map_addr, output, YW: map row address.
REQ-013 SHALL have map_rd_en, output, 1: map read strobe.
REQ-014 SHALL have map_row, input, COLS: wall bits; 1 = wall. Data is valid the cycle after map_addr/map_rd_en (1-cycle synchronous ROM).
REQ-015 SHALL have ghost_x/ghost_y, output, XW/YW: registered ghost tile.
REQ-016 SHALL have dir, output, 2: last move direction. Encoding 0 U, 1 L, 2 D, 3 R.
REQ-017 SHALL have busy, output, 1: high whenever state != IDLE.
REQ-018 SHALL have step_done, output, 1: one-cycle pulse when a step completes.

Function
REQ-019 SHALL implement the FSM IDLE -> FETCH_U -> FETCH_M -> FETCH_D -> CAPT_D -> DECIDE -> DONE -> IDLE, advancing one state per cycle after IDLE.
REQ-020 SHALL leave IDLE only when step_req=1, and SHALL ignore step_req while busy (no queuing).
REQ-021 SHALL drive map_rd_en=1 in FETCH_U/M/D, with map_addr = y-1, y, y+1 respectively.
REQ-022 SHALL capture map_row into the up, mid and down row registers in FETCH_M, FETCH_D and CAPT_D respectively.
REQ-023 SHALL, when step_req is sampled at cycle 0, assert step_done in cycle 6 only, and ghost_x/ghost_y/dir SHALL show the new values in that same cycle.
REQ-024 SHALL define a candidate as open when its wall bit is 0.
REQ-025 SHALL treat U as wall at y=0 and D as wall at y=ROWS-1; the fetched row is ignored in those cases.
REQ-026 SHALL, for L at x=0 and R at x=COLS-1: with WRAP=1, make the candidate tile x=COLS-1 or x=0 respectively, taken from the mid row; with WRAP=0, treat it as wall.
REQ-027 SHALL exclude the reverse of dir from candidates, unless it is the only open direction or a reversal is pending.
REQ-028 SHALL select the effective target as target_x/target_y in CHASE and SCAT_X/SCAT_Y in SCATTER.
REQ-029 SHALL, in CHASE and SCATTER, choose the open candidate with minimum |dx|+|dy| to the target. Signed differences are (XW+1)/(YW+1) bits wide; the sum is max(XW,YW)+2 bits. Ties resolve in priority U, L, D, R.
REQ-030 SHALL, in FRIGHTENED, scan from index lfsr[1:0] upward mod 4 and take the first eligible open direction.
REQ-031 SHALL implement the LFSR as 8 bits, polynomial x^8+x^6+x^5+x^4+1, advancing once per accepted step_req.
REQ-032 SHALL, in FROZEN, leave position and dir unchanged while the FSM still runs and still pulses step_done.
REQ-033 SHALL, when no direction is eligible, hold position and dir and still pulse step_done.
REQ-034 SHALL set the reverse-pending flag whenever mode changes between any two non-FROZEN values.
REQ-035 SHALL, on the next DECIDE with reverse-pending set, move in the reverse of dir if it is open, else apply normal selection; the flag SHALL clear in that DECIDE.
REQ-036 SHALL sample mode and target only in DECIDE.

Reset
REQ-037 SHALL, while reset=1, force: state IDLE; ghost_x=START_X, ghost_y=START_Y; dir=1 (L); busy=0, step_done=0; map_rd_en=0, map_addr=0; lfsr=8'hE1; reverse-pending=0; row registers cleared.
REQ-038 SHALL abort any in-flight step on reset with no step_done and no position update.

Verification
REQ-039 SHALL verify: all-open map, CHASE, ghost (10,14), dir R, target (15,14) -> step_done at cycle 6, ghost (11,14), dir R, map_addr sequence 13,14,15.
REQ-040 SHALL verify: same start but R tile walled and U/D open, target (15,10) -> ghost (10,13), dir U.
REQ-041 SHALL verify: WRAP=1, ghost (0,14), dir L, only L and R open, target (21,14) -> ghost (21,14); with WRAP=0 -> reverse taken, ghost (1,14), dir R.
REQ-042 SHALL verify: CHASE step, then mode switched to SCATTER, reverse open -> next step moves opposite the prior dir and the flag clears; FROZEN step -> position unchanged and step_done still at cycle 6.
REQ-043 SHALL verify: reset asserted in FETCH_D -> next cycle busy=0, ghost=(10,14), no step_done; step_req while busy is ignored with exactly one step_done.

Source files
------------

// File: rtl/ghost_move_if.sv
// Ghost movement controller bus: step handshake, mode/target inputs, map ROM port and ghost state.
interface ghost_move_if #(
    parameter int unsigned COLS = 22,
    parameter int unsigned ROWS = 32
);
    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);

    logic            step_req;
    logic [1:0]      mode;
    logic [XW-1:0]   target_x;
    logic [YW-1:0]   target_y;
    logic [YW-1:0]   map_addr;
    logic            map_rd_en;
    logic [COLS-1:0] map_row;
    logic [XW-1:0]   ghost_x;
    logic [YW-1:0]   ghost_y;
    logic [1:0]      dir;
    logic            busy;
    logic            step_done;

    modport master (
        output step_req, mode, target_x, target_y, map_row,
        input  map_addr, map_rd_en, ghost_x, ghost_y, dir, busy, step_done
    );

    modport slave (
        input  step_req, mode, target_x, target_y, map_row,
        output map_addr, map_rd_en, ghost_x, ghost_y, dir, busy, step_done
    );
endinterface

// File: rtl/ghost_move_ctrl.sv
// Moves one ghost a single tile per step request: fetches the three map rows around it,
// then picks a direction by chase/scatter distance, pseudo-random choice, or holds when frozen.
module ghost_move_ctrl #(
    parameter int unsigned COLS    = 22,
    parameter int unsigned ROWS    = 32,
    parameter int unsigned START_X = 10,
    parameter int unsigned START_Y = 14,
    parameter int unsigned SCAT_X  = 21,
    parameter int unsigned SCAT_Y  = 0,
    parameter bit          WRAP    = 1'b1
) (
    input logic         clk,
    input logic         reset,
    ghost_move_if.slave bus
);
    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned DW = ((XW > YW) ? XW : YW) + 2;

    localparam logic [1:0] M_CHASE  = 2'd0;
    localparam logic [1:0] M_SCAT   = 2'd1;
    localparam logic [1:0] M_FRIGHT = 2'd2;
    localparam logic [1:0] M_FROZEN = 2'd3;

    localparam logic [1:0] D_U = 2'd0;
    localparam logic [1:0] D_L = 2'd1;
    localparam logic [1:0] D_D = 2'd2;
    localparam logic [1:0] D_R = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_U = 3'd1,
        FETCH_M = 3'd2,
        FETCH_D = 3'd3,
        CAPT_D  = 3'd4,
        DECIDE  = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic            rd_en_q, rd_en_nxt;
    logic [YW-1:0]   addr_q, addr_nxt;

    logic [XW-1:0]   gx;
    logic [YW-1:0]   gy;
    logic [1:0]      dir_q;
    logic [7:0]      lfsr;
    logic [1:0]      last_mode;
    logic            last_vld;
    logic [COLS-1:0] row_u, row_m, row_d;

    logic [3:0]      open_c, elig_c;
    logic [1:0]      rev_c, sel_c, idx_c;
    logic            pend_c, move_c, found_c;
    logic [XW-1:0]   tx_c;
    logic [YW-1:0]   ty_c;
    logic [DW-1:0]   best_c;
    logic [XW-1:0]   cand_x [4];
    logic [YW-1:0]   cand_y [4];
    logic [DW-1:0]   dist_c [4];

    function automatic logic [DW-1:0] manhattan(input logic [XW-1:0] cx, input logic [YW-1:0] cy,
                                                 input logic [XW-1:0] ax, input logic [YW-1:0] ay);
        logic signed [XW:0] dx;
        logic signed [YW:0] dy;
        logic [XW:0]        mx;
        logic [YW:0]        my;
        dx = $signed({1'b0, cx}) - $signed({1'b0, ax});
        dy = $signed({1'b0, cy}) - $signed({1'b0, ay});
        mx = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
        my = dy[YW] ? $unsigned(-dy) : $unsigned(dy);
        return DW'(mx) + DW'(my);
    endfunction

    // Sequencer: next state plus next values of the registered control outputs.
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        rd_en_nxt = 1'b0;
        addr_nxt  = '0;
        unique case (state)
            IDLE:    if (bus.step_req) state_nxt = FETCH_U;
            FETCH_U: state_nxt = FETCH_M;
            FETCH_M: state_nxt = FETCH_D;
            FETCH_D: state_nxt = CAPT_D;
            CAPT_D:  state_nxt = DECIDE;
            DECIDE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        case (state_nxt)
            FETCH_U: begin rd_en_nxt = 1'b1; addr_nxt = gy - YW'(1); end
            FETCH_M: begin rd_en_nxt = 1'b1; addr_nxt = gy;          end
            FETCH_D: begin rd_en_nxt = 1'b1; addr_nxt = gy + YW'(1); end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state   <= state_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            rd_en_q <= rd_en_nxt;
            addr_q  <= addr_nxt;
        end
    end

    // Neighbour openness, candidate tiles and their distances to the effective target.
    always_comb begin
        open_c    = 4'b0000;
        open_c[0] = (gy != '0) && !row_u[gx];
        open_c[2] = (gy != YW'(ROWS - 1)) && !row_d[gx];
        if (gx == '0) open_c[1] = WRAP && !row_m[COLS-1];
        else          open_c[1] = !row_m[gx - XW'(1)];
        if (gx == XW'(COLS - 1)) open_c[3] = WRAP && !row_m[0];
        else                     open_c[3] = !row_m[gx + XW'(1)];

        cand_x[0] = gx;
        cand_y[0] = gy - YW'(1);
        cand_x[1] = (gx == '0) ? XW'(COLS - 1) : gx - XW'(1);
        cand_y[1] = gy;
        cand_x[2] = gx;
        cand_y[2] = gy + YW'(1);
        cand_x[3] = (gx == XW'(COLS - 1)) ? '0 : gx + XW'(1);
        cand_y[3] = gy;

        tx_c = (bus.mode == M_SCAT) ? XW'(SCAT_X) : bus.target_x;
        ty_c = (bus.mode == M_SCAT) ? YW'(SCAT_Y) : bus.target_y;
        for (int i = 0; i < 4; i++) dist_c[i] = manhattan(cand_x[i], cand_y[i], tx_c, ty_c);

        rev_c  = dir_q ^ 2'd2;
        pend_c = last_vld && (bus.mode != M_FROZEN) && (bus.mode != last_mode);
        elig_c = open_c;
        if (open_c != (4'b0001 << rev_c)) elig_c[rev_c] = 1'b0;
    end

    // Direction choice; strict less-than keeps the U, L, D, R tie priority.
    always_comb begin
        move_c  = 1'b0;
        sel_c   = D_U;
        found_c = 1'b0;
        best_c  = '1;
        idx_c   = 2'd0;
        if (bus.mode != M_FROZEN) begin
            if (pend_c && open_c[rev_c]) begin
                found_c = 1'b1;
                sel_c   = rev_c;
            end else if (bus.mode == M_FRIGHT) begin
                for (int k = 0; k < 4; k++) begin
                    idx_c = lfsr[1:0] + 2'(k);
                    if (!found_c && elig_c[idx_c]) begin
                        found_c = 1'b1;
                        sel_c   = idx_c;
                    end
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (elig_c[i] && (!found_c || dist_c[i] < best_c)) begin
                        found_c = 1'b1;
                        best_c  = dist_c[i];
                        sel_c   = 2'(i);
                    end
                end
            end
            move_c = found_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gx        <= XW'(START_X);
            gy        <= YW'(START_Y);
            dir_q     <= D_L;
            lfsr      <= 8'hE1;
            last_mode <= M_CHASE;
            last_vld  <= 1'b0;
            row_u     <= '0;
            row_m     <= '0;
            row_d     <= '0;
        end else begin
            if (state == IDLE && bus.step_req)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == FETCH_M) row_u <= bus.map_row;
            if (state == FETCH_D) row_m <= bus.map_row;
            if (state == CAPT_D)  row_d <= bus.map_row;
            if (state == DECIDE) begin
                // FROZEN does not count as a mode for reversal tracking.
                if (bus.mode != M_FROZEN) begin
                    last_mode <= bus.mode;
                    last_vld  <= 1'b1;
                end
                if (move_c) begin
                    gx    <= cand_x[sel_c];
                    gy    <= cand_y[sel_c];
                    dir_q <= sel_c;
                end
            end
        end
    end

    assign bus.map_addr  = addr_q;
    assign bus.map_rd_en = rd_en_q;
    assign bus.ghost_x   = gx;
    assign bus.ghost_y   = gy;
    assign bus.dir       = dir_q;
    assign bus.busy      = busy_q;
    assign bus.step_done = done_q;
endmodule

// File: tb/tb_ghost_move_ctrl.sv
// Directed bench for ghost_move_ctrl: two instances (tunnel wrap on/off) sharing stimulus and a map ROM model.
module tb_ghost_move_ctrl;
    localparam int unsigned COLS = 22;
    localparam int unsigned ROWS = 32;
    localparam int unsigned XW   = $clog2(COLS);
    localparam int unsigned YW   = $clog2(ROWS);
    localparam int unsigned PW   = XW + YW + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [COLS-1:0] map_mem [ROWS];
    logic [COLS-1:0] ra, rb;

    int            done_cyc, n_done, n_rd;
    logic [YW-1:0] a0, a1, a2;
    logic [PW-1:0] at_done;

    always #5 clk = ~clk;

    ghost_move_if #(.COLS(COLS), .ROWS(ROWS)) ia ();
    ghost_move_if #(.COLS(COLS), .ROWS(ROWS)) ib ();

    ghost_move_ctrl #(.COLS(COLS), .ROWS(ROWS), .START_X(10), .START_Y(14),
                      .SCAT_X(21), .SCAT_Y(0), .WRAP(1'b1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));

    ghost_move_ctrl #(.COLS(COLS), .ROWS(ROWS), .START_X(10), .START_Y(14),
                      .SCAT_X(21), .SCAT_Y(0), .WRAP(1'b0))
        dut_b (.clk(clk), .reset(reset), .bus(ib));

    assign ib.step_req = ia.step_req;
    assign ib.mode     = ia.mode;
    assign ib.target_x = ia.target_x;
    assign ib.target_y = ia.target_y;
    assign ia.map_row  = ra;
    assign ib.map_row  = rb;

    // One-cycle synchronous map ROM, one read port per instance.
    always @(posedge clk) begin
        if (ia.map_rd_en) ra <= map_mem[ia.map_addr];
        if (ib.map_rd_en) rb <= map_mem[ib.map_addr];
    end

    function automatic logic [PW-1:0] ep(input int x, input int y, input int d);
        return {XW'(x), YW'(y), 2'(d)};
    endfunction

    function automatic logic [PW-1:0] pos_a();
        return {ia.ghost_x, ia.ghost_y, ia.dir};
    endfunction

    function automatic logic [PW-1:0] pos_b();
        return {ib.ghost_x, ib.ghost_y, ib.dir};
    endfunction

    task automatic set_map(input logic [COLS-1:0] up, input logic [COLS-1:0] mid, input logic [COLS-1:0] dn);
        for (int r = 0; r < ROWS; r++) map_mem[r] = '0;
        map_mem[13] = up;
        map_mem[14] = mid;
        map_mem[15] = dn;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ia.step_req = 1'b0;
        ia.mode     = 2'd0;
        ia.target_x = '0;
        ia.target_y = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issues one step request and watches a fixed 10-cycle window; cycle c is after the c-th edge.
    task automatic do_step();
        done_cyc = -1;
        n_done   = 0;
        n_rd     = 0;
        a0 = '0; a1 = '0; a2 = '0;
        at_done  = '0;
        ia.step_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) ia.step_req = 1'b0;
            if (ia.map_rd_en) begin
                case (n_rd)
                    0: a0 = ia.map_addr;
                    1: a1 = ia.map_addr;
                    2: a2 = ia.map_addr;
                    default: ;
                endcase
                n_rd++;
            end
            if (ia.step_done) begin
                n_done++;
                done_cyc = c;
                at_done  = pos_a();
            end
        end
    endtask

    // Brings the ghost back to (10,14) heading R without any mode change.
    task automatic setup_r();
        logic [COLS-1:0] mid;
        do_reset();
        set_map('0, '0, '0);
        ia.target_x = 5'd0; ia.target_y = 5'd14;
        do_step();
        mid = COLS'(1) << 10;
        set_map('1, ~mid, '1);
        do_step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pos_a() !== ep(10, 14, 1)) begin bad++; $display("FAIL reset_pos: got %h want %h", pos_a(), ep(10, 14, 1)); end
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ia.busy); end
        total++; if (ia.step_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ia.step_done); end
        total++; if ({ia.map_rd_en, ia.map_addr} !== 6'd0) begin bad++; $display("FAIL reset_map: got %b/%0d want 0/0", ia.map_rd_en, ia.map_addr); end
    endtask

    task automatic test_chase_basic();
        logic [COLS-1:0] mid;
        do_reset();
        set_map('0, '0, '0);
        ia.mode = 2'd0; ia.target_x = 5'd0; ia.target_y = 5'd14;
        do_step();
        total++; if (pos_a() !== ep(9, 14, 1)) begin bad++; $display("FAIL chase_left: got %h want %h", pos_a(), ep(9, 14, 1)); end
        mid = COLS'(1) << 10;
        set_map('1, ~mid, '1);
        do_step();
        total++; if (pos_a() !== ep(10, 14, 3)) begin bad++; $display("FAIL dead_end_reverse: got %h want %h", pos_a(), ep(10, 14, 3)); end
        set_map('0, '0, '0);
        ia.target_x = 5'd15; ia.target_y = 5'd14;
        do_step();
        total++; if (done_cyc !== 6 || n_done !== 1) begin bad++; $display("FAIL chase_done: got cyc %0d n %0d want cyc 6 n 1", done_cyc, n_done); end
        total++; if (at_done !== ep(11, 14, 3)) begin bad++; $display("FAIL chase_pos_at_done: got %h want %h", at_done, ep(11, 14, 3)); end
        total++; if (n_rd !== 3 || a0 !== 5'd13 || a1 !== 5'd14 || a2 !== 5'd15) begin
            bad++; $display("FAIL chase_addr: got n %0d %0d,%0d,%0d want 3 13,14,15", n_rd, a0, a1, a2);
        end
    endtask

    task automatic test_wall_turn();
        setup_r();
        set_map('0, COLS'(1) << 11, '0);
        ia.mode = 2'd0; ia.target_x = 5'd15; ia.target_y = 5'd10;
        do_step();
        total++; if (pos_a() !== ep(10, 13, 0)) begin bad++; $display("FAIL wall_turn: got %h want %h", pos_a(), ep(10, 13, 0)); end
        total++; if (done_cyc !== 6) begin bad++; $display("FAIL wall_turn_done: got %0d want 6", done_cyc); end
    endtask

    task automatic test_mode_reverse();
        do_reset();
        set_map('0, '0, '0);
        ia.mode = 2'd0; ia.target_x = 5'd0; ia.target_y = 5'd14;
        do_step();
        ia.mode = 2'd1;
        do_step();
        total++; if (pos_a() !== ep(10, 14, 3)) begin bad++; $display("FAIL scatter_reverse: got %h want %h", pos_a(), ep(10, 14, 3)); end
        do_step();
        total++; if (pos_a() !== ep(10, 13, 0)) begin bad++; $display("FAIL scatter_flag_clear: got %h want %h", pos_a(), ep(10, 13, 0)); end
        ia.mode = 2'd3;
        do_step();
        total++; if (pos_a() !== ep(10, 13, 0)) begin bad++; $display("FAIL frozen_pos: got %h want %h", pos_a(), ep(10, 13, 0)); end
        total++; if (done_cyc !== 6 || n_done !== 1) begin bad++; $display("FAIL frozen_done: got cyc %0d n %0d want cyc 6 n 1", done_cyc, n_done); end
    endtask

    task automatic test_reset_abort();
        int cnt;
        do_reset();
        set_map('0, '0, '0);
        ia.mode = 2'd0; ia.target_x = 5'd0; ia.target_y = 5'd14;
        do_step();
        total++; if (pos_a() !== ep(9, 14, 1)) begin bad++; $display("FAIL abort_pre: got %h want %h", pos_a(), ep(9, 14, 1)); end
        ia.step_req = 1'b1;
        @(posedge clk); #1 ia.step_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_fetch: got %b want 1", ia.busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", ia.busy); end
        total++; if (pos_a() !== ep(10, 14, 1)) begin bad++; $display("FAIL abort_pos: got %h want %h", pos_a(), ep(10, 14, 1)); end
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (ia.step_done) cnt++;
            @(posedge clk); #1;
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", cnt); end
        cnt = 0;
        ia.step_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 6) ia.step_req = 1'b0;
            if (ia.step_done) cnt++;
        end
        total++; if (cnt !== 1) begin bad++; $display("FAIL busy_ignore_done: got %0d want 1", cnt); end
        total++; if (pos_a() !== ep(9, 14, 1)) begin bad++; $display("FAIL busy_ignore_pos: got %h want %h", pos_a(), ep(9, 14, 1)); end
    endtask

    task automatic test_wrap();
        logic [COLS-1:0] mid;
        do_reset();
        set_map('0, '0, '0);
        ia.mode = 2'd0; ia.target_x = 5'd0; ia.target_y = 5'd14;
        repeat (10) do_step();
        total++; if (pos_a() !== ep(0, 14, 1) || pos_b() !== ep(0, 14, 1)) begin
            bad++; $display("FAIL wrap_pre: got %h/%h want %h", pos_a(), pos_b(), ep(0, 14, 1));
        end
        mid = (COLS'(1) << 21) | (COLS'(1) << 1);
        set_map('1, ~mid, '1);
        ia.target_x = 5'd21; ia.target_y = 5'd14;
        do_step();
        total++; if (pos_a() !== ep(21, 14, 1)) begin bad++; $display("FAIL wrap_on: got %h want %h", pos_a(), ep(21, 14, 1)); end
        total++; if (pos_b() !== ep(1, 14, 3)) begin bad++; $display("FAIL wrap_off: got %h want %h", pos_b(), ep(1, 14, 3)); end
        total++; if (done_cyc !== 6) begin bad++; $display("FAIL wrap_done: got %0d want 6", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_chase_basic();
        test_wall_turn();
        test_mode_reverse();
        test_reset_abort();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
